// File: rtl/banked_sram.sv
// Multi-port, multi-bank synchronous SRAM model with per-bank round-robin arbitration.
// Optional macro BANKED_SRAM_OUT_REG_EN adds an output register stage (read latency 2).
module banked_sram #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 32,
    parameter int unsigned NP = 2,
    parameter int unsigned NB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NP-1:0]        req_vld,
    output logic [NP-1:0]        req_rdy,
    input  logic [NP-1:0]        req_wen,
    input  logic [NP*AW-1:0]     req_addr,
    input  logic [NP*DW-1:0]     req_wdata,
    input  logic [NP*DW/8-1:0]   req_be,
    output logic [NP-1:0]        rsp_vld,
    output logic [NP*DW-1:0]     rsp_rdata
);

    localparam int unsigned BEW   = DW / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned BSW   = (LB > 0) ? LB : 1;
    localparam int unsigned IW    = AW - LB;
    localparam int unsigned DEPTH = 1 << IW;
    localparam int unsigned PW    = (NP > 1) ? $clog2(NP) : 1;

    if (DW == 0 || (DW % 8) != 0 || NP < 1 || NP > 8 || NB < 1 ||
        (NB & (NB - 1)) != 0 || NB > (1 << (AW - 1))) begin : g_bad_cfg
        $error("banked_sram: parameter out of range");
    end

    logic [BSW-1:0] p_bank [NP];
    logic [IW-1:0]  p_idx  [NP];

    logic [NB-1:0]  gnt_vld;
    logic [PW-1:0]  gnt_port [NB];
    logic [PW-1:0]  rr_ptr   [NB];
    logic [PW-1:0]  rr_nxt   [NB];

    logic [NB-1:0]  w_en;
    logic [IW-1:0]  w_idx  [NB];
    logic [DW-1:0]  w_data [NB];
    logic [BEW-1:0] w_be   [NB];

    logic [DW-1:0]  mem [NB][DEPTH];

    logic [NP-1:0]    rd_vld;
    logic [NP*DW-1:0] rd_data;

    // Address split: low bits select the bank, the rest index within it
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            p_bank[p] = BSW'(req_addr[p*AW +: AW] & AW'(NB - 1));
            p_idx[p]  = IW'(req_addr[p*AW +: AW] >> LB);
        end
    end

    // Per-bank round-robin: first matching requester at or after rr_ptr
    always_comb begin
        logic [PW-1:0] c;
        c = '0;
        for (int b = 0; b < NB; b++) begin
            gnt_vld[b]  = 1'b0;
            gnt_port[b] = '0;
            for (int k = 0; k < NP; k++) begin
                c = PW'((32'(rr_ptr[b]) + 32'(k)) % NP);
                if (!gnt_vld[b] && req_vld[c] && (p_bank[c] == BSW'(b))) begin
                    gnt_vld[b]  = 1'b1;
                    gnt_port[b] = c;
                end
            end
            rr_nxt[b] = (gnt_port[b] == PW'(NP - 1)) ? '0 : gnt_port[b] + PW'(1);
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            req_rdy[p] = rst_n && gnt_vld[p_bank[p]] && (gnt_port[p_bank[p]] == PW'(p));
        end
    end

    // Winner's write payload routed to its bank
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_en[b]   = rst_n && gnt_vld[b] && req_wen[gnt_port[b]];
            w_idx[b]  = p_idx[gnt_port[b]];
            w_data[b] = req_wdata[32'(gnt_port[b]) * DW +: DW];
            w_be[b]   = req_be[32'(gnt_port[b]) * BEW +: BEW];
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < BEW; i++) begin
                if (w_en[b] && w_be[b][i]) begin
                    mem[b][w_idx[b]][8*i +: 8] <= w_data[b][8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (gnt_vld[b]) begin
                    rr_ptr[b] <= rr_nxt[b];
                end
            end
        end
    end

    // Bank read register: captures the word as it stands at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= '0;
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                rd_vld[p] <= req_rdy[p] && !req_wen[p];
                if (req_rdy[p] && !req_wen[p]) begin
                    rd_data[p*DW +: DW] <= mem[p_bank[p]][p_idx[p]];
                end
            end
        end
    end

`ifdef BANKED_SRAM_OUT_REG_EN
    logic [NP-1:0]    out_vld;
    logic [NP*DW-1:0] out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= '0;
            out_data <= '0;
        end else begin
            out_vld <= rd_vld;
            for (int p = 0; p < NP; p++) begin
                if (rd_vld[p]) begin
                    out_data[p*DW +: DW] <= rd_data[p*DW +: DW];
                end
            end
        end
    end

    assign rsp_vld   = out_vld;
    assign rsp_rdata = out_data;
`else
    assign rsp_vld   = rd_vld;
    assign rsp_rdata = rd_data;
`endif

endmodule
